gf2_mult_ds: RTL and testbench

- Parametrised digit-serial GF(2) polynomial multiplier: carry-less W×W product, no field reduction.
- Processes D bits of operand b per clock, so area/latency is tunable per instance.
- Adds a valid/ready handshake on input and output, plus an optional multiply-accumulate mode (result XORed into the previous result) for Karatsuba recombination in the GF(2^233) datapath.

---
 rtl/gf2_digit_mult.sv | 17 +
 rtl/gf2_mult_ds.sv | 83 ++++++++
 tb/tb_gf2_mult_ds.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gf2_digit_mult.sv
// gf2_digit_mult: combinational W x D carry-less product
module gf2_digit_mult #(
  parameter int W = 30,
  parameter int D = 10
) (
  input  logic [W-1:0]     a_i,
  input  logic [D-1:0]     b_i,
  output logic [W+D-2:0]   p_o
);
  logic [W+D-2:0] a_ext;
  assign a_ext = (W+D-1)'(a_i);
  // XOR one shifted copy of a per set bit of the digit
  always_comb begin
    p_o = '0;
    for (int i = 0; i < D; i++) p_o = p_o ^ (b_i[i] ? (a_ext << i) : '0);
  end
endmodule

// File: rtl/gf2_mult_ds.sv
// gf2_mult_ds: digit-serial carry-less W x W multiplier with optional accumulate
module gf2_mult_ds #(
  parameter int W = 30,
  parameter int D = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_acc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_d
);
  localparam int NDIG = (W + D - 1) / D;
  localparam int BW = NDIG * D;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [BW-1:0]  b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d, res_q, res_d, acc_next;
  logic [W+D-2:0] prod;
  gf2_digit_mult #(.W(W), .D(D)) u_dm (
    .a_i(a_q),
    .b_i(b_q[D-1:0]),
    .p_o(prod)
  );
  assign acc_next = acc_q ^ ((2*W)'(prod) << (cnt_q * D));
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_d = res_q;
  // b shifts right one digit per cycle so the current digit is always at the bottom
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    res_d = res_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d = in_a;
        b_d = BW'(in_b);
        cnt_d = '0;
        acc_d = in_acc ? res_q : '0;
        state_d = BUSY;
      end
      BUSY: begin
        acc_d = acc_next;
        b_d = b_q >> D;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          res_d = acc_next;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state register; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_gf2_mult_ds.sv
// tb_gf2_mult_ds: random and directed checks of gf2_mult_ds for D in {10,7,1,30}
module tb_gf2_mult_ds;
  localparam int W = 30;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  logic [3:0] in_valid, in_ready, in_acc, out_valid, out_ready;
  logic [W-1:0] in_a [4];
  logic [W-1:0] in_b [4];
  logic [2*W-1:0] out_d [4];
  logic [2*W-1:0] last [4];
  logic [2*W-1:0] expv [4];
  int total = 0, bad = 0;
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : u
      gf2_mult_ds #(.W(W), .D(g == 0 ? 10 : g == 1 ? 7 : g == 2 ? 1 : 30)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid[g]),
        .in_ready(in_ready[g]),
        .in_a(in_a[g]),
        .in_b(in_b[g]),
        .in_acc(in_acc[g]),
        .out_valid(out_valid[g]),
        .out_ready(out_ready[g]),
        .out_d(out_d[g])
      );
    end
  endgenerate

  function automatic int ndig(input int k);
    return k == 0 ? 3 : k == 1 ? 5 : k == 2 ? 30 : 1;
  endfunction

  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] & b[j]) r[i+j] = ~r[i+j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic acc);
    int n = 0;
    while (!in_ready[k] && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(in_ready[k]), 64'd1);
    in_valid[k] = 1;
    in_a[k] = a;
    in_b[k] = b;
    in_acc[k] = acc;
    tick();
    in_valid[k] = 0;
    in_a[k] = W'($urandom);
    in_b[k] = W'($urandom);
    in_acc[k] = 1'($urandom_range(1));
    chk("ready_busy", 64'(in_ready[k]), 64'd0);
    expv[k] = (acc ? last[k] : '0) ^ clmul(a, b);
    last[k] = expv[k];
  endtask

  task automatic finish(input int k, output logic [2*W-1:0] r);
    int lat = 0;
    logic rdy_seen = 0;
    while (!out_valid[k] && lat < 100) begin
      if (in_ready[k]) rdy_seen = 1;
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(ndig(k)));
    chk("ready_in_flight", 64'(rdy_seen), 64'd0);
    chk("result", 64'(out_d[k]), 64'(expv[k]));
    chk("ready_done", 64'(in_ready[k]), 64'd0);
    r = out_d[k];
    out_ready[k] = 1;
    tick();
    out_ready[k] = 0;
    chk("ready_after", 64'(in_ready[k]), 64'd1);
    chk("valid_after", 64'(out_valid[k]), 64'd0);
    chk("hold_after", 64'(out_d[k]), 64'(r));
  endtask

  task automatic op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic acc,
                    output logic [2*W-1:0] r);
    start(k, a, b, acc);
    finish(k, r);
  endtask

  task automatic do_reset;
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 4; k++) last[k] = '0;
  endtask

  initial begin
    logic [2*W-1:0] r, r0;
    int n;
    in_valid = '0;
    in_acc = '0;
    out_ready = '0;
    for (int k = 0; k < 4; k++) begin
      in_a[k] = '0;
      in_b[k] = '0;
      last[k] = '0;
      expv[k] = '0;
    end
    rst = 1;
    tick();
    do_reset();
    chk("rst_ready", 64'(in_ready), 64'hF);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_out", 64'(out_d[0]), 64'h0);
    op(0, 30'd3, 30'd3, 0, r);
    chk("p3x3", 64'(r), 64'h5);
    op(0, 30'h3FFFFFFF, 30'd3, 0, r);
    chk("p_ones_x3", 64'(r), 64'h40000001);
    op(0, 30'd3, 30'd3, 0, r);
    chk("acc_base", 64'(r), 64'h5);
    op(0, 30'd1, 30'd4, 1, r);
    chk("acc_add", 64'(r), 64'h1);
    op(0, 30'd1, 30'd1, 0, r);
    chk("acc_clear", 64'(r), 64'h1);
    start(0, 30'd5, 30'd7, 0);
    n = 0;
    while (!out_valid[0] && n < 100) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd3);
    r0 = out_d[0];
    chk("bp_result", 64'(r0), 64'h1B);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'(i % 2);
      in_a[0] = W'($urandom);
      in_b[0] = W'($urandom);
      tick();
      chk("bp_valid", 64'(out_valid[0]), 64'd1);
      chk("bp_hold", 64'(out_d[0]), 64'(r0));
      chk("bp_ready", 64'(in_ready[0]), 64'd0);
    end
    in_valid[0] = 0;
    out_ready[0] = 1;
    tick();
    out_ready[0] = 0;
    chk("bp_release_ready", 64'(in_ready[0]), 64'd1);
    chk("bp_release_valid", 64'(out_valid[0]), 64'd0);
    chk("bp_release_hold", 64'(out_d[0]), 64'(r0));
    op(1, 30'h20000000, 30'h20000000, 0, r);
    chk("d7_top", 64'(r), 64'h400000000000000);
    start(0, W'($urandom), W'($urandom), 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 4; k++) last[k] = '0;
    chk("mid_rst_ready", 64'(in_ready[0]), 64'd1);
    chk("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_out", 64'(out_d[0]), 64'h0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid[0]) n++;
    end
    chk("mid_rst_no_valid", 64'(n), 64'd0);
    op(0, 30'd2, 30'd2, 0, r);
    chk("after_rst", 64'(r), 64'h4);
    op(3, W'($urandom), W'($urandom), 1, r);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 12; i++)
        op(k, W'($urandom), W'($urandom), 1'($urandom_range(1)), r);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
